// File: rtl/osd_regaccess_ctrl.sv
// rtl/osd_regaccess_ctrl.sv - debug register access endpoint: built-in MODID/MODVERSION/CTRL plus host forwarding
// Optional host ack timeout enabled by defining OSD_REGACCESS_CTRL_TIMEOUT_EN.
module osd_regaccess_ctrl #(
   parameter logic [15:0] MODID          = 16'h0000,
   parameter logic [15:0] MODVERSION     = 16'h0000,
   parameter int          NUM_USER_REGS  = 4,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [9:0]  id_i,
   input  logic [15:0] debug_in_data_i,
   input  logic        debug_in_valid_i,
   input  logic        debug_in_last_i,
   output logic        debug_in_ready_o,
   output logic [15:0] debug_out_data_o,
   output logic        debug_out_valid_o,
   output logic        debug_out_last_o,
   input  logic        debug_out_ready_i,
   output logic        reg_request_o,
   output logic        reg_write_o,
   output logic [15:0] reg_addr_o,
   output logic [15:0] reg_wdata_o,
   input  logic        reg_ack_i,
   input  logic        reg_err_i,
   input  logic [15:0] reg_rdata_i,
   output logic        stall_o
);

   typedef enum logic [3:0] {
      IDLE, SRC, TYPE, ADDR, WDATA, DROP, HOST,
      RESP_DEST, RESP_SRC, RESP_TYPE, RESP_DATA
   } state_t;

   localparam logic [3:0]  REQ_READ   = 4'b0010;
   localparam logic [3:0]  REQ_WRITE  = 4'b0011;
   localparam logic [3:0]  RESP_READ  = 4'b1000;
   localparam logic [3:0]  RESP_WRITE = 4'b1001;
   localparam logic [3:0]  RESP_ERR   = 4'b1111;
   localparam logic [16:0] USER_END   = 17'h0200 + 17'(NUM_USER_REGS);

   state_t      state_q, state_d;
   logic [9:0]  src_q, src_d;
   logic        wr_q, wr_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rdata_q, rdata_d;
   logic [3:0]  resp_type_q, resp_type_d;
   logic        ctrl_q, ctrl_d;

   logic        in_accept, in_fire, go_err, fin_valid, fin_wr;
   logic [15:0] fin_addr, fin_wdata;

`ifdef OSD_REGACCESS_CTRL_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt_q;
   logic            to_expired;

   always_ff @(posedge clk_i) begin
      if (rst_i || state_q != HOST) to_cnt_q <= '0;
      else                          to_cnt_q <= to_cnt_q + 1'b1;
   end
   assign to_expired = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         src_q       <= '0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         resp_type_q <= RESP_ERR;
         ctrl_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         src_q       <= src_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         resp_type_q <= resp_type_d;
         ctrl_q      <= ctrl_d;
      end
   end

   assign in_accept = (state_q inside {IDLE, SRC, TYPE, ADDR, WDATA, DROP});
   assign in_fire   = in_accept && debug_in_valid_i && !rst_i;

   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      resp_type_d = resp_type_q;
      ctrl_d      = ctrl_q;
      go_err      = 1'b0;
      fin_valid   = 1'b0;
      fin_wr      = wr_q;
      fin_addr    = addr_q;
      fin_wdata   = wdata_q;
      case (state_q)
         IDLE: if (in_fire) begin
            if (debug_in_last_i) go_err = 1'b1;
            else                 state_d = SRC;
         end
         SRC: if (in_fire) begin
            src_d = debug_in_data_i[9:0];
            if (debug_in_last_i) go_err = 1'b1;
            else                 state_d = TYPE;
         end
         TYPE: if (in_fire) begin
            wr_d = (debug_in_data_i[15:12] == REQ_WRITE);
            if (debug_in_last_i) go_err = 1'b1;
            else if (debug_in_data_i[15:12] == REQ_READ || debug_in_data_i[15:12] == REQ_WRITE)
               state_d = ADDR;
            else
               state_d = DROP;
         end
         ADDR: if (in_fire) begin
            addr_d = debug_in_data_i;
            if (wr_q) begin
               if (debug_in_last_i) go_err = 1'b1;
               else                 state_d = WDATA;
            end else if (debug_in_last_i) begin
               fin_valid = 1'b1;
               fin_addr  = debug_in_data_i;
            end else begin
               state_d = DROP;
            end
         end
         WDATA: if (in_fire) begin
            wdata_d = debug_in_data_i;
            if (debug_in_last_i) begin
               fin_valid = 1'b1;
               fin_wdata = debug_in_data_i;
            end else begin
               state_d = DROP;
            end
         end
         DROP: if (in_fire && debug_in_last_i) go_err = 1'b1;
         HOST: begin
            if (reg_err_i) begin
               go_err = 1'b1;
            end else if (reg_ack_i) begin
               rdata_d     = reg_rdata_i;
               resp_type_d = wr_q ? RESP_WRITE : RESP_READ;
               state_d     = RESP_DEST;
            end
`ifdef OSD_REGACCESS_CTRL_TIMEOUT_EN
            else if (to_expired) go_err = 1'b1;
`endif
         end
         RESP_DEST: if (debug_out_ready_i) state_d = RESP_SRC;
         RESP_SRC:  if (debug_out_ready_i) state_d = RESP_TYPE;
         RESP_TYPE: if (debug_out_ready_i) state_d = (resp_type_q == RESP_READ) ? RESP_DATA : IDLE;
         RESP_DATA: if (debug_out_ready_i) state_d = IDLE;
         default:   state_d = IDLE;
      endcase

      // Address decode happens on the edge that consumes the final request word.
      if (fin_valid) begin
         state_d = RESP_DEST;
         if (fin_addr[15:1] == 15'h0) begin
            if (fin_wr) go_err = 1'b1;
            else begin
               resp_type_d = RESP_READ;
               rdata_d     = fin_addr[0] ? MODVERSION : MODID;
            end
         end else if (fin_addr == 16'h0002) begin
            if (fin_wr) begin
               ctrl_d      = fin_wdata[0];
               resp_type_d = RESP_WRITE;
            end else begin
               resp_type_d = RESP_READ;
               rdata_d     = {15'h0, ctrl_q};
            end
         end else if (fin_addr >= 16'h0200 && {1'b0, fin_addr} < USER_END) begin
            state_d = HOST;
         end else begin
            go_err = 1'b1;
         end
      end

      if (go_err) begin
         state_d     = RESP_DEST;
         resp_type_d = RESP_ERR;
      end
   end

   always_comb begin
      debug_in_ready_o  = in_accept && !rst_i;
      debug_out_valid_o = (state_q inside {RESP_DEST, RESP_SRC, RESP_TYPE, RESP_DATA}) && !rst_i;
      debug_out_data_o  = 16'h0;
      debug_out_last_o  = 1'b0;
      case (state_q)
         RESP_DEST: debug_out_data_o = {6'h0, src_q};
         RESP_SRC:  debug_out_data_o = {6'h0, id_i};
         RESP_TYPE: begin
            debug_out_data_o = {resp_type_q, 12'h0};
            debug_out_last_o = (resp_type_q != RESP_READ);
         end
         RESP_DATA: begin
            debug_out_data_o = rdata_q;
            debug_out_last_o = 1'b1;
         end
         default: ;
      endcase
      reg_request_o = (state_q == HOST) && !rst_i;
      reg_write_o   = wr_q;
      reg_addr_o    = addr_q;
      reg_wdata_o   = wdata_q;
      stall_o       = ctrl_q;
   end

endmodule

// File: tb/tb_osd_regaccess_ctrl.sv
// tb/tb_osd_regaccess_ctrl.sv - directed self-checking bench for osd_regaccess_ctrl
module tb_osd_regaccess_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  id;
   logic [15:0] din_data;
   logic        din_valid, din_last, din_ready;
   logic [15:0] dout_data;
   logic        dout_valid, dout_last, dout_ready;
   logic        reg_request, reg_write, reg_ack, reg_err, stall;
   logic [15:0] reg_addr, reg_wdata, reg_rdata;

   int checks = 0;
   int errors = 0;
   int req_cycles = 0;
   int req_mark;

   always #5 clk = ~clk;
   always @(posedge clk) if (reg_request) req_cycles <= req_cycles + 1;

   osd_regaccess_ctrl #(
      .MODID(16'h0005), .MODVERSION(16'h0007), .NUM_USER_REGS(4), .TIMEOUT_CYCLES(10)
   ) dut (
      .clk_i(clk), .rst_i(rst), .id_i(id),
      .debug_in_data_i(din_data), .debug_in_valid_i(din_valid), .debug_in_last_i(din_last),
      .debug_in_ready_o(din_ready),
      .debug_out_data_o(dout_data), .debug_out_valid_o(dout_valid), .debug_out_last_o(dout_last),
      .debug_out_ready_i(dout_ready),
      .reg_request_o(reg_request), .reg_write_o(reg_write), .reg_addr_o(reg_addr),
      .reg_wdata_o(reg_wdata), .reg_ack_i(reg_ack), .reg_err_i(reg_err), .reg_rdata_i(reg_rdata),
      .stall_o(stall)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_word(input logic [15:0] w, input logic l);
      int n = 0;
      din_valid = 1'b1; din_data = w; din_last = l;
      while (!din_ready && n < 50) begin @(negedge clk); n++; end
      check("in_ready_timeout", (n < 50), 1);
      @(negedge clk);
   endtask

   task automatic send_pkt(input logic [15:0] w0, w1, w2, w3, w4, w5, input int n);
      logic [15:0] w [6];
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3; w[4] = w4; w[5] = w5;
      for (int i = 0; i < n; i++) send_word(w[i], (i == n - 1));
      din_valid = 1'b0; din_last = 1'b0;
   endtask

   task automatic get_resp(input string tag, input logic [15:0] e0, e1, e2, e3,
                           input int n, input bit toggle);
      logic [15:0] e [4];
      int i = 0;
      int guard = 0;
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      while (i < n && guard < 100) begin
         dout_ready = toggle ? ((guard % 2) == 1) : 1'b1;
         #1;
         if (dout_valid) begin
            check({tag, "_data"}, dout_data, e[i]);
            check({tag, "_last"}, dout_last, (i == n - 1));
            if (dout_ready) i++;
         end
         @(negedge clk);
         guard++;
      end
      check({tag, "_complete"}, i, n);
      dout_ready = 1'b1;
      check({tag, "_idle_after"}, dout_valid, 0);
   endtask

   initial begin
      rst = 1'b1; id = 10'h003;
      din_data = '0; din_valid = 1'b0; din_last = 1'b0; dout_ready = 1'b1;
      reg_ack = 1'b0; reg_err = 1'b0; reg_rdata = '0;
      @(negedge clk); @(negedge clk);
      check("rst_in_ready", din_ready, 0);
      check("rst_out_valid", dout_valid, 0);
      check("rst_reg_request", reg_request, 0);
      check("rst_stall", stall, 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", din_ready, 1);

      // Built-in reads, response starts right after final word
      send_pkt(16'h0003, 16'h0010, 16'h2000, 16'h0000, 0, 0, 4);
      check("t1_latency", dout_valid, 1);
      get_resp("t1_modid", 16'h0010, 16'h0003, 16'h8000, 16'h0005, 4, 0);
      send_pkt(16'h0003, 16'h0011, 16'h2000, 16'h0001, 0, 0, 4);
      get_resp("t1_modver", 16'h0011, 16'h0003, 16'h8000, 16'h0007, 4, 0);

      // CTRL write / read-back
      send_pkt(16'h0003, 16'h0010, 16'h3000, 16'h0002, 16'h0001, 0, 5);
      check("t2_stall", stall, 1);
      get_resp("t2_wr", 16'h0010, 16'h0003, 16'h9000, 0, 3, 0);
      send_pkt(16'h0003, 16'h0010, 16'h2000, 16'h0002, 0, 0, 4);
      get_resp("t2_rd", 16'h0010, 16'h0003, 16'h8000, 16'h0001, 4, 1);

      // Host read with 3-cycle ack and toggled backpressure
      req_mark = req_cycles;
      send_pkt(16'h0003, 16'h0021, 16'h2000, 16'h0201, 0, 0, 4);
      check("t3_req_on", reg_request, 1);
      check("t3_addr", reg_addr, 16'h0201);
      check("t3_write", reg_write, 0);
      check("t3_out_idle", dout_valid, 0);
      @(negedge clk);
      @(negedge clk);
      reg_ack = 1'b1; reg_rdata = 16'hBEEF;
      @(negedge clk);
      reg_ack = 1'b0; reg_rdata = 16'h0000;
      check("t3_req_off", reg_request, 0);
      check("t3_req_cycles", req_cycles - req_mark, 3);
      get_resp("t3_host", 16'h0021, 16'h0003, 16'h8000, 16'hBEEF, 4, 1);

      // Host write answered with reg_err
      send_pkt(16'h0003, 16'h0022, 16'h3000, 16'h0203, 16'h1234, 0, 5);
      check("t3w_req", reg_request, 1);
      check("t3w_write", reg_write, 1);
      check("t3w_wdata", reg_wdata, 16'h1234);
      reg_err = 1'b1;
      @(negedge clk);
      reg_err = 1'b0;
      get_resp("t3w_err", 16'h0022, 16'h0003, 16'hF000, 0, 3, 0);

      // Decode errors never touch the host
      req_mark = req_cycles;
      send_pkt(16'h0003, 16'h0030, 16'h2000, 16'h0300, 0, 0, 4);
      get_resp("t4_oow", 16'h0030, 16'h0003, 16'hF000, 0, 3, 0);
      send_pkt(16'h0003, 16'h0031, 16'h2000, 16'h0204, 0, 0, 4);
      get_resp("t4_past_win", 16'h0031, 16'h0003, 16'hF000, 0, 3, 0);
      send_pkt(16'h0003, 16'h0032, 16'h3000, 16'h0000, 16'h5555, 0, 5);
      get_resp("t4_wr_ro", 16'h0032, 16'h0003, 16'hF000, 0, 3, 0);
      check("t4_no_req", req_cycles - req_mark, 0);

      // Malformed packets
      send_pkt(16'h0003, 16'h0040, 16'h2000, 0, 0, 0, 3);
      get_resp("t5_short", 16'h0040, 16'h0003, 16'hF000, 0, 3, 0);
      send_pkt(16'h0003, 16'h0041, 16'h2000, 16'h0000, 16'hAAAA, 16'hBBBB, 6);
      get_resp("t5_long", 16'h0041, 16'h0003, 16'hF000, 0, 3, 0);
      send_pkt(16'h0003, 16'h0042, 16'h5000, 16'h0000, 0, 0, 4);
      get_resp("t5_badtype", 16'h0042, 16'h0003, 16'hF000, 0, 3, 0);
      send_pkt(16'h0003, 16'h0043, 16'h2000, 16'h0000, 0, 0, 4);
      get_resp("t5_recover", 16'h0043, 16'h0003, 16'h8000, 16'h0005, 4, 0);
      check("t5_no_req", req_cycles - req_mark, 0);

`ifdef OSD_REGACCESS_CTRL_TIMEOUT_EN
      begin
         int n = 0;
         send_pkt(16'h0003, 16'h0050, 16'h2000, 16'h0200, 0, 0, 4);
         while (reg_request && n < 50) begin @(negedge clk); n++; end
         check("t6_timeout_cycles", n, 10);
         dout_ready = 1'b0;
         reg_ack = 1'b1; reg_rdata = 16'h1111;
         @(negedge clk);
         reg_ack = 1'b0;
         get_resp("t6_timeout", 16'h0050, 16'h0003, 16'hF000, 0, 3, 0);
         @(negedge clk);
         check("t6_no_extra", dout_valid, 0);
      end
`endif

      // Reset mid-response clears CTRL and aborts the response
      send_pkt(16'h0003, 16'h0060, 16'h3000, 16'h0002, 16'h0001, 0, 5);
      get_resp("t7_wr", 16'h0060, 16'h0003, 16'h9000, 0, 3, 0);
      check("t7_stall_set", stall, 1);
      dout_ready = 1'b0;
      send_pkt(16'h0003, 16'h0061, 16'h2000, 16'h0002, 0, 0, 4);
      @(negedge clk);
      check("t7_resp_pending", dout_valid, 1);
      rst = 1'b1;
      #1;
      check("t7_rst_valid", dout_valid, 0);
      check("t7_rst_ready", din_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("t7_post_valid", dout_valid, 0);
      check("t7_post_stall", stall, 0);
      check("t7_post_req", reg_request, 0);
      check("t7_post_ready", din_ready, 1);
      dout_ready = 1'b1;
      @(negedge clk);
      send_pkt(16'h0003, 16'h0062, 16'h2000, 16'h0002, 0, 0, 4);
      get_resp("t7_ctrl_cleared", 16'h0062, 16'h0003, 16'h8000, 16'h0000, 4, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
